// File: rtl/sram_like_pkg.sv
// Shared encodings for the sram-like bus: transfer sizes and the responder FSM states.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/sram_be_decode.sv
// Byte-lane enable decode from transfer size and the low address bits.
module sram_be_decode
    import sram_like_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be
);

    always_comb begin
        be = 4'b1111;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            // Halfwords pick the upper or lower pair; addr_lo[0] is don't-care.
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side responder for the sram-like req/addr_ok/data_ok bus: one outstanding
// transaction, fixed LATENCY from acceptance to data_ok, back-to-back acceptance in RESP.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [31:0]       mem_q [2**ADDR_W];
    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              data_ok_q;
    logic [31:0]       rdata_q;

    logic [3:0]        be_d;
    logic [ADDR_W-1:0] idx_d;
    logic              accept;
    logic              commit;
    logic              enter_resp;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_wr;
    logic [31:0]       mem_word;
    logic [31:0]       rd_word;
    logic              unused_addr_hi;

    sram_be_decode u_be_decode (
        .size    (size),
        .addr_lo (addr[1:0]),
        .be      (be_d)
    );

    assign idx_d          = addr[ADDR_W+1:2];
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign addr_ok    = (state_q != ST_WAIT);
    assign accept     = req && addr_ok;
    assign commit     = (state_q == ST_RESP) && wr_q;
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 4'd1));

    // From WAIT the read targets the latched request; otherwise it is the one being accepted.
    assign rd_idx   = (state_q == ST_WAIT) ? idx_q : idx_d;
    assign rd_wr    = (state_q == ST_WAIT) ? wr_q  : wr;
    assign mem_word = mem_q[rd_idx];

    // A read accepted in a write's RESP cycle sees the lanes committed on that same edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
            assign rd_word[8*gi +: 8] = (commit && be_q[gi] && (idx_q == rd_idx))
                                        ? wdata_q[8*gi +: 8] : mem_word[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            be_q      <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
            if (enter_resp) begin
                data_ok_q <= 1'b1;
                rdata_q   <= rd_wr ? 32'd0 : rd_word;
            end
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        wr_q    <= wr;
                        be_q    <= be_d;
                        idx_q   <= idx_d;
                        wdata_q <= wdata;
                        cnt_q   <= LAT_M1;
                        if (LATENCY == 1) state_q <= ST_RESP;
                        else              state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit && resetn) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;

endmodule
